seq_mult_iter: RTL and testbench
================================

// Module: seq_mult_iter
// PURPOSE
//  Parametrised iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, one multiplier bit per clock.
//  Area-lean successor to the 16-bit combinational array multiplier; trades latency for a single W-bit adder.
//  Sits between a valid/ready producer and consumer in the arithmetic datapath; one operation in flight at a time.
// PARAMETERS
//  WIDTH   16   operand width in bits (>=2); product is 2*WIDTH bits
//  CNT_W   $clog2(WIDTH+1)   iteration-counter width (derived, not overridden)
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         operand pair a/b valid
//  in_ready   out  1         block idle, can accept operands
//  a          in   WIDTH     multiplicand
//  b          in   WIDTH     multiplier
//  out_valid  out  1         product valid, held until accepted
//  out_ready  in   1         consumer accepts product
//  product    out  2*WIDTH   a*b
//  busy       out  1         high in CALC or DONE
// BEHAVIOUR
//  Reset: one clock; rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, in_ready=1 once released,
//   out_valid=0, product=0, busy=0, counter=0, internal regs=0. Reset mid-operation aborts; no product emitted.
//  FSM: IDLE -> CALC on in_valid&&in_ready; CALC -> DONE when counter==WIDTH-1 step completes;
//   DONE -> IDLE on out_valid&&out_ready. No other transitions.
//  in_ready = (state==IDLE), combinational from state. Operands are sampled only on the accept edge;
//   a/b changes after acceptance are ignored.
//  Datapath: on accept, M<=a, P[2W-1:0]<={W'b0,b}, cnt<=0.
//   Each CALC cycle: sum[W:0]=P[2W-1:W]+(P[0]?M:0); P<={sum,P[W-1:1]}; cnt<=cnt+1. The carry is kept (W+1 bits).
//  Latency: accept at edge N -> out_valid=1 after edge N+WIDTH (WIDTH CALC cycles); WIDTH=16 -> 16 cycles.
//  DONE: product=P, stable, out_valid=1 until the out_ready handshake. out_ready ignored when out_valid=0.
//  Handshake edge: out_valid drops on the edge after out_valid&&out_ready; in_ready rises on that same edge.
//   Next accept is possible one cycle later. Max throughput: one product per WIDTH+2 cycles.
//  in_valid asserted while busy: not accepted, no effect; producer must hold it until in_ready.
//  product register retains the last result after return to IDLE (out_valid=0); it is overwritten only in DONE.
//  Width rules: all arithmetic unsigned; no overflow possible (max (2^W-1)^2 < 2^(2W)).
//  Zero operands take full latency; no early termination.
// CONFIGURATION
//  MULT_SIGNED_EN defined: a, b, product are two's complement. On accept, M<=|a| and P low<=|b|.
//   The sign bit s=a[W-1]^b[W-1] is registered. On the transition into DONE, product=s ? -P : P.
//   |-(2^(W-1))| = 2^(W-1) fits in W unsigned bits; latency unchanged.
//  MULT_SIGNED_EN undefined: pure unsigned behaviour as above; no sign logic synthesised.
// TESTING
//  1 rst_n=0 for 3 cycles mid-CALC -> out_valid=0, in_ready=1 after release, no stray product; next op correct.
//  2 Unsigned: a=16'hFFFF, b=16'hFFFF, out_ready=1 -> product=32'hFFFE0001, out_valid exactly 16 cycles after accept.
//  3 a=16'h1234, b=16'h0000, then a=16'h0001, b=16'h8000 -> products 32'h0, 32'h00008000.
//  4 Backpressure: out_ready=0 for 10 cycles in DONE -> product, out_valid stable; in_valid pulses ignored, in_ready=0.
//  5 Back-to-back: in_valid held high with 4 operand pairs, out_ready=1 -> 4 correct products, 18-cycle spacing.
//  6 MULT_SIGNED_EN: -1*-1=32'h1; -3*5=32'hFFFFFFF1; -32768*-32768=32'h40000000; 32767*-32768=32'hC0008000.

Source files
------------

// File: rtl/seq_mult_iter_if.sv
// Valid/ready operand and product bundle for seq_mult_iter.
// The producer/consumer side uses master; the multiplier uses slave.
interface seq_mult_iter_if #(
   parameter int WIDTH = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/seq_mult_iter.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier bit per clock.
// Define MULT_SIGNED_EN for two's-complement operands and product (sign-magnitude around the unsigned core).
module seq_mult_iter #(
   parameter int WIDTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   seq_mult_iter_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t               state;
   state_t               state_next;
   logic [WIDTH-1:0]     m;
   logic [2*WIDTH-1:0]   p;
   logic [2*WIDTH-1:0]   p_step;
   logic [2*WIDTH-1:0]   product_r;
   logic [2*WIDTH-1:0]   result;
   logic [CNT_W-1:0]     cnt;
   logic [WIDTH:0]       sum;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic                 accept;
   logic                 last_step;

   assign accept    = bus.in_valid && (state == IDLE);
   assign last_step = (state == CALC) && (cnt == CNT_W'(WIDTH - 1));

`ifdef MULT_SIGNED_EN
   logic sign_r;

   // Magnitudes go through the unsigned core; the most negative value maps to 2^(W-1), which still fits.
   assign a_mag  = bus.a[WIDTH-1] ? -bus.a : bus.a;
   assign b_mag  = bus.b[WIDTH-1] ? -bus.b : bus.b;
   assign result = sign_r ? -p_step : p_step;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sign_r <= 1'b0;
      else if (accept)
         sign_r <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
   end
`else
   assign a_mag  = bus.a;
   assign b_mag  = bus.b;
   assign result = p_step;
`endif

   // The adder carry becomes the new top bit as the partial product shifts right.
   always_comb begin
      sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
      p_step = {sum, p[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid) state_next = CALC;
         CALC:    if (last_step)    state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
      bus.busy      = (state != IDLE);
   end

   assign bus.product = product_r;

   // The product register only changes on the final step, so it holds the last result through IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m         <= '0;
         p         <= '0;
         cnt       <= '0;
         product_r <= '0;
      end else if (accept) begin
         m   <= a_mag;
         p   <= {{WIDTH{1'b0}}, b_mag};
         cnt <= '0;
      end else if (state == CALC) begin
         p   <= p_step;
         cnt <= cnt + CNT_W'(1);
         if (last_step)
            product_r <= result;
      end
   end
endmodule

// File: tb/tb_seq_mult_iter.sv
// Scoreboard bench for seq_mult_iter: driver pushes model products, a negedge monitor pops and compares.
// Honours MULT_SIGNED_EN in its reference model when the design is built with it.
module tb_seq_mult_iter;
   localparam int WIDTH = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   mon_acc;
   bit   prev_valid = 1'b0;
   bit   force_rdy  = 1'b1;
   bit   rdy_val    = 1'b1;

   logic [2*WIDTH-1:0] exp_q[$];
   int                 acc_q[$];

   seq_mult_iter_if #(.WIDTH(WIDTH)) bus();

   seq_mult_iter #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [2*WIDTH-1:0] ref_mult(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef MULT_SIGNED_EN
      logic signed [2*WIDTH-1:0] sx, sy;
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
`else
      logic [2*WIDTH-1:0] ux, uy;
      ux = x;
      uy = y;
      return ux * uy;
`endif
   endfunction

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
      n_checks++;
      if (actual !== required) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, required, $time);
      end
   endtask

   task automatic report_fail(input string name);
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s (t=%0t)", name, $time);
   endtask

   // out_ready changes just after each rising edge so it is settled when the monitor samples.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = force_rdy ? rdy_val : 1'($urandom_range(0, 1));
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (bus.out_valid && !prev_valid) begin
            if (acc_q.size() == 0) begin
               report_fail("stray_out_valid");
            end else begin
               mon_acc = acc_q.pop_front();
               check_output("latency", 64'(cyc - mon_acc), 64'(WIDTH));
            end
         end
         if (bus.out_valid)
            check_output("in_ready_in_done", 64'(bus.in_ready), 64'd0);
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0)
               report_fail("stray_product");
            else
               check_output("product", 64'(bus.product), 64'(exp_q.pop_front()));
         end
         prev_valid = bus.out_valid;
      end
   end

   // Called at a falling edge; returns one falling edge after the accepting rising edge.
   task automatic apply_stimulus(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, output int acc_cyc);
      bus.a        = aa;
      bus.b        = bb;
      bus.in_valid = 1'b1;
      acc_cyc      = -1;
      for (int i = 0; i < 200; i++) begin
         if (bus.in_ready) begin
            acc_cyc = cyc + 1;
            break;
         end
         @(negedge clk);
      end
      if (acc_cyc < 0) begin
         report_fail("accept_timeout");
      end else begin
         exp_q.push_back(ref_mult(aa, bb));
         acc_q.push_back(acc_cyc);
      end
      @(negedge clk);
   endtask

   task automatic run_op(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
      int acc;
      apply_stimulus(aa, bb, acc);
      bus.in_valid = 1'b0;
      bus.a        = WIDTH'($urandom);
      bus.b        = WIDTH'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 1000; i++) begin
         if (exp_q.size() == 0 && !bus.busy) break;
         @(negedge clk);
      end
      if (exp_q.size() != 0 || bus.busy)
         report_fail("drain_timeout");
   endtask

   initial begin
      int acc;
      int prev_acc;
      logic [WIDTH-1:0] ta, tb;

      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      #1;
      check_output("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check_output("reset_busy", 64'(bus.busy), 64'd0);
      check_output("reset_product", 64'(bus.product), 64'd0);
      check_output("reset_in_ready", 64'(bus.in_ready), 64'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] full-scale operands");
      force_rdy = 1'b1;
      rdy_val   = 1'b1;
      run_op(16'hFFFF, 16'hFFFF);
      drain();
`ifdef MULT_SIGNED_EN
      check_output("retained_ffff", 64'(bus.product), 64'h1);
`else
      check_output("retained_ffff", 64'(bus.product), 64'hFFFE0001);
`endif

      $display("[TB] zero and single-bit operands");
      run_op(16'h1234, 16'h0000);
      run_op(16'h0001, 16'h8000);
      drain();
`ifdef MULT_SIGNED_EN
      check_output("retained_8000", 64'(bus.product), 64'hFFFF8000);
`else
      check_output("retained_8000", 64'(bus.product), 64'h00008000);
`endif

      $display("[TB] reset during calculation");
      run_op(WIDTH'($urandom), WIDTH'($urandom));
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      acc_q.delete();
      #1;
      check_output("midreset_out_valid", 64'(bus.out_valid), 64'd0);
      check_output("midreset_busy", 64'(bus.busy), 64'd0);
      check_output("midreset_product", 64'(bus.product), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_output("post_reset_in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      run_op(16'h00FF, 16'h0101);
      drain();

      $display("[TB] backpressure in DONE");
      rdy_val = 1'b0;
      @(negedge clk);
      ta = WIDTH'($urandom);
      tb = WIDTH'($urandom);
      run_op(ta, tb);
      for (int i = 0; i < 100; i++) begin
         if (bus.out_valid) break;
         @(negedge clk);
      end
      if (!bus.out_valid) report_fail("done_timeout");
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.a        = WIDTH'($urandom);
         bus.b        = WIDTH'($urandom);
         @(negedge clk);
         check_output("bp_out_valid", 64'(bus.out_valid), 64'd1);
         check_output("bp_in_ready", 64'(bus.in_ready), 64'd0);
         check_output("bp_product", 64'(bus.product), 64'(ref_mult(ta, tb)));
      end
      bus.in_valid = 1'b0;
      rdy_val      = 1'b1;
      drain();

      $display("[TB] back-to-back with in_valid held");
      prev_acc = -1;
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(WIDTH'($urandom), WIDTH'($urandom), acc);
         if (k > 0)
            check_output("b2b_spacing", 64'(acc - prev_acc), 64'(WIDTH + 2));
         prev_acc = acc;
      end
      bus.in_valid = 1'b0;
      drain();

`ifdef MULT_SIGNED_EN
      $display("[TB] signed corner cases");
      run_op(16'hFFFF, 16'hFFFF);
      run_op(16'hFFFD, 16'h0005);
      run_op(16'h8000, 16'h8000);
      run_op(16'h7FFF, 16'h8000);
      drain();
      check_output("retained_signed", 64'(bus.product), 64'hC0008000);
`endif

      $display("[TB] randomized traffic with random out_ready");
      force_rdy = 1'b0;
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 5))
            0:       ta = '0;
            1:       ta = '1;
            2:       ta = WIDTH'(1) << (WIDTH - 1);
            default: ta = WIDTH'($urandom);
         endcase
         tb = (k % 7 == 3) ? '1 : WIDTH'($urandom);
         run_op(ta, tb);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();
      force_rdy = 1'b1;
      rdy_val   = 1'b1;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout (t=%0t)", $time);
      $fatal(1, "[TB] simulation time limit reached");
   end
endmodule
